// File: rtl/car_sensor_sequencer.sv
// Emulates the A/B beam sensors of a car park gate for one enter or exit pass.
// Define CAR_SENSOR_SEQ_ABORT_EN to add the abort input and aborted output.
module car_sensor_sequencer #(
    parameter int PHASE_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_enter,
    input  logic             start_exit,
`ifdef CAR_SENSOR_SEQ_ABORT_EN
    input  logic             abort,
    output logic             aborted,
`endif
    output logic             A,
    output logic             B,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] enter_cnt,
    output logic [CNT_W-1:0] exit_cnt
);

    localparam int PW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(PHASE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PH1,
        PH2,
        PH3
    } state_t;

    state_t        state;
    logic          dir;
    logic [PW-1:0] ph_cnt;
    logic          abort_req;

`ifdef CAR_SENSOR_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Exit mirrors enter: the inner beam is broken first.
    function automatic logic [1:0] ab_of(input state_t s, input logic d);
        logic [1:0] ab;
        ab = 2'b00;
        unique case (s)
            IDLE: ab = 2'b00;
            PH1:  ab = d ? 2'b01 : 2'b10;
            PH2:  ab = 2'b11;
            PH3:  ab = d ? 2'b10 : 2'b01;
        endcase
        return ab;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            dir       <= 1'b0;
            ph_cnt    <= '0;
            A         <= 1'b0;
            B         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            enter_cnt <= '0;
            exit_cnt  <= '0;
`ifdef CAR_SENSOR_SEQ_ABORT_EN
            aborted   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef CAR_SENSOR_SEQ_ABORT_EN
            aborted <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (start_enter || start_exit) begin
                        state  <= PH1;
                        dir    <= !start_enter;
                        ph_cnt <= '0;
                        busy   <= 1'b1;
                        {A, B} <= ab_of(PH1, !start_enter);
                    end
                end
                default: begin
                    if (abort_req) begin
                        state  <= IDLE;
                        ph_cnt <= '0;
                        busy   <= 1'b0;
                        {A, B} <= 2'b00;
`ifdef CAR_SENSOR_SEQ_ABORT_EN
                        aborted <= 1'b1;
`endif
                    end else if (ph_cnt != PH_LAST) begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end else begin
                        ph_cnt <= '0;
                        unique case (state)
                            PH1: begin
                                state  <= PH2;
                                {A, B} <= ab_of(PH2, dir);
                            end
                            PH2: begin
                                state  <= PH3;
                                {A, B} <= ab_of(PH3, dir);
                            end
                            default: begin
                                state  <= IDLE;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                                {A, B} <= 2'b00;
                                if (dir)
                                    exit_cnt <= exit_cnt + 1'b1;
                                else
                                    enter_cnt <= enter_cnt + 1'b1;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_car_sensor_sequencer.sv
// Scoreboard bench for car_sensor_sequencer (PHASE_CYCLES=2, CNT_W=2).
// Stimulus queues per-cycle expectations; a negedge monitor checks them.
module tb_car_sensor_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start_enter = 1'b0;
    logic       start_exit = 1'b0;
    logic       abort_i = 1'b0;
    logic       aborted_o;
    logic       A, B, busy, done;
    logic [1:0] enter_cnt, exit_cnt;

    typedef struct {
        int         cyc;
        logic [8:0] v;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   cur_cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    car_sensor_sequencer #(
        .PHASE_CYCLES(2),
        .CNT_W       (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start_enter(start_enter),
        .start_exit (start_exit),
`ifdef CAR_SENSOR_SEQ_ABORT_EN
        .abort      (abort_i),
        .aborted    (aborted_o),
`endif
        .A          (A),
        .B          (B),
        .busy       (busy),
        .done       (done),
        .enter_cnt  (enter_cnt),
        .exit_cnt   (exit_cnt)
    );

`ifndef CAR_SENSOR_SEQ_ABORT_EN
    assign aborted_o = 1'b0;
`endif

    always @(posedge clk) cur_cyc <= cur_cyc + 1;

    always @(negedge clk) begin
        logic [8:0] got;
        exp_t       e;
        got = {A, B, busy, done, aborted_o, enter_cnt, exit_cnt};
        while (q.size() > 0 && q[0].cyc <= cur_cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cur_cyc) begin
                failures++;
                $display("FAIL %s stale cyc=%0d now=%0d", e.tag, e.cyc, cur_cyc);
            end else if (got !== e.v) begin
                failures++;
                $display("FAIL %s cyc=%0d got {AB,busy,done,abt,en,ex}=%b want=%b",
                         e.tag, cur_cyc, got, e.v);
            end
        end
    end

    task automatic cyc(input logic se, input logic sx, input logic rn,
                       input logic ab_in, input logic [1:0] ab,
                       input logic bz, input logic dn, input logic abt,
                       input logic [1:0] en, input logic [1:0] ex,
                       input string tag);
        exp_t e;
        @(negedge clk);
        start_enter = se;
        start_exit  = sx;
        reset_n     = rn;
        abort_i     = ab_in;
        e.cyc = cur_cyc + 1;
        e.v   = {ab, bz, dn, abt, en, ex};
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic idle(input logic [1:0] en, input logic [1:0] ex);
        cyc(0, 0, 1, 0, 2'b00, 0, 0, 0, en, ex, "idle");
    endtask

    // Seven calls: start, five busy cycles, then the done cycle.
    task automatic run_seq(input logic se, input logic sx,
                           input logic [6:1] sx_mask,
                           input logic [1:0] en_b, input logic [1:0] ex_b,
                           input logic [1:0] en_a, input logic [1:0] ex_a,
                           input string tag);
        logic [1:0] p1, p3;
        p1 = se ? 2'b10 : 2'b01;
        p3 = se ? 2'b01 : 2'b10;
        cyc(se, sx, 1, 0, p1, 1, 0, 0, en_b, ex_b, tag);
        cyc(0, sx_mask[1], 1, 0, p1, 1, 0, 0, en_b, ex_b, tag);
        cyc(0, sx_mask[2], 1, 0, 2'b11, 1, 0, 0, en_b, ex_b, tag);
        cyc(0, sx_mask[3], 1, 0, 2'b11, 1, 0, 0, en_b, ex_b, tag);
        cyc(0, sx_mask[4], 1, 0, p3, 1, 0, 0, en_b, ex_b, tag);
        cyc(0, sx_mask[5], 1, 0, p3, 1, 0, 0, en_b, ex_b, tag);
        cyc(0, sx_mask[6], 1, 0, 2'b00, 0, 1, 0, en_a, ex_a, {tag, "_done"});
    endtask

    initial begin
        int waited;
        cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 2'd0, 2'd0, "reset");
        cyc(1, 1, 0, 0, 2'b00, 0, 0, 0, 2'd0, 2'd0, "reset_vs_start");
        idle(2'd0, 2'd0);

        run_seq(1, 0, 6'b000000, 2'd0, 2'd0, 2'd1, 2'd0, "enter");
        idle(2'd1, 2'd0);
        run_seq(0, 1, 6'b000000, 2'd1, 2'd0, 2'd1, 2'd1, "exit");
        idle(2'd1, 2'd1);

        run_seq(1, 1, 6'b000000, 2'd1, 2'd1, 2'd2, 2'd1, "both");
        idle(2'd2, 2'd1);
        run_seq(1, 0, 6'b000100, 2'd2, 2'd1, 2'd3, 2'd1, "ph2_pulse");
        idle(2'd3, 2'd1);
        run_seq(1, 0, 6'b111000, 2'd3, 2'd1, 2'd0, 2'd1, "held_wrap");
        run_seq(0, 1, 6'b000000, 2'd0, 2'd1, 2'd0, 2'd2, "b2b_exit");
        idle(2'd0, 2'd2);

        cyc(1, 0, 1, 0, 2'b10, 1, 0, 0, 2'd0, 2'd2, "rst_mid");
        cyc(0, 0, 1, 0, 2'b10, 1, 0, 0, 2'd0, 2'd2, "rst_mid");
        cyc(0, 0, 1, 0, 2'b11, 1, 0, 0, 2'd0, 2'd2, "rst_mid");
        cyc(0, 0, 0, 0, 2'b00, 0, 0, 0, 2'd0, 2'd0, "rst_ph2");
        idle(2'd0, 2'd0);
        idle(2'd0, 2'd0);

        run_seq(1, 0, 6'b000000, 2'd0, 2'd0, 2'd1, 2'd0, "wrap1");
        idle(2'd1, 2'd0);
        run_seq(1, 0, 6'b000000, 2'd1, 2'd0, 2'd2, 2'd0, "wrap2");
        idle(2'd2, 2'd0);
        run_seq(1, 0, 6'b000000, 2'd2, 2'd0, 2'd3, 2'd0, "wrap3");
        idle(2'd3, 2'd0);
        run_seq(1, 0, 6'b000000, 2'd3, 2'd0, 2'd0, 2'd0, "wrap4");
        idle(2'd0, 2'd0);

`ifdef CAR_SENSOR_SEQ_ABORT_EN
        cyc(1, 0, 1, 0, 2'b10, 1, 0, 0, 2'd0, 2'd0, "abort_seq");
        cyc(0, 0, 1, 0, 2'b10, 1, 0, 0, 2'd0, 2'd0, "abort_seq");
        cyc(0, 0, 1, 0, 2'b11, 1, 0, 0, 2'd0, 2'd0, "abort_seq");
        cyc(0, 0, 1, 1, 2'b00, 0, 0, 1, 2'd0, 2'd0, "abort_ph2");
        cyc(0, 0, 1, 1, 2'b00, 0, 0, 0, 2'd0, 2'd0, "abort_idle");
        idle(2'd0, 2'd0);
        run_seq(1, 0, 6'b000000, 2'd0, 2'd0, 2'd1, 2'd0, "after_abort");
        idle(2'd1, 2'd0);
`endif

        waited = 0;
        while (q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/car_sensor_sequencer.md
CAR_SENSOR_SEQUENCER -- requirements
Module: car_sensor_sequencer

Interface
REQ-001 The block SHALL have parameter PHASE_CYCLES, default 4: clock cycles each sensor phase is held; legal values are 1 or more.
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the completed-event counters.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port start_enter, input, 1 bit: request one car-entering sensor sequence.
REQ-006 The block SHALL have port start_exit, input, 1 bit: request one car-exiting sensor sequence.
REQ-007 The block SHALL have port A, output, 1 bit: emulated outer beam sensor; 1 = blocked.
REQ-008 The block SHALL have port B, output, 1 bit: emulated inner beam sensor; 1 = blocked.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a sequence is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking sequence completion.
REQ-011 The block SHALL have port enter_cnt, output, CNT_W bits: number of completed enter sequences.
REQ-012 The block SHALL have port exit_cnt, output, CNT_W bits: number of completed exit sequences.

Function
REQ-013 The block SHALL register all outputs, with no combinational path from any input to any output.
REQ-014 The FSM SHALL have states IDLE, PH1, PH2 and PH3, plus a direction flag dir (0 = enter, 1 = exit) captured at start.
REQ-015 In IDLE, the block SHALL drive A=0, B=0 and busy=0.
REQ-016 In IDLE, start_enter=1 SHALL cause the next cycle to be PH1 with dir=0 and busy=1.
REQ-017 In IDLE, start_exit=1 with start_enter=0 SHALL cause the next cycle to be PH1 with dir=1 and busy=1.
REQ-018 If start_enter and start_exit are both 1 in IDLE, enter SHALL win and the exit request SHALL be dropped.
REQ-019 For dir=0, A/B SHALL be PH1=10, PH2=11, PH3=01.
REQ-020 For dir=1, A/B SHALL be PH1=01, PH2=11, PH3=10.
REQ-021 Each phase SHALL last exactly PHASE_CYCLES cycles, timed by a phase counter cleared on every phase entry; a sequence SHALL take 3*PHASE_CYCLES busy cycles.
REQ-022 After the last PH3 cycle, the block SHALL return to IDLE with A=B=0 and done=1 for exactly that first IDLE cycle.
REQ-023 The counter matching dir (enter_cnt or exit_cnt) SHALL increment by 1 on the same edge that asserts done.
REQ-024 Counters SHALL wrap modulo 2^CNT_W, e.g. all-ones + 1 = 0.
REQ-025 start_enter and start_exit SHALL be ignored while busy=1; requests are not queued.
REQ-026 A start SHALL be accepted in the done cycle, so back-to-back sequences are separated by exactly one A=B=00 cycle.

Reset
REQ-027 When reset_n=0 at a rising edge, the next state SHALL be IDLE with A=0, B=0, busy=0, done=0, enter_cnt=0, exit_cnt=0, dir=0 and the phase counter at 0.
REQ-028 Reset SHALL take priority over start and abort, including mid-sequence; no done pulse or count SHALL result from an interrupted sequence.

Configuration
REQ-029 When macro CAR_SENSOR_SEQ_ABORT_EN is defined, the block SHALL add input abort (1 bit) and output aborted (1 bit, reset 0).
REQ-030 With CAR_SENSOR_SEQ_ABORT_EN defined, abort=1 in PH1, PH2 or PH3 SHALL cause the next cycle to be IDLE with A=B=0, aborted=1 for one cycle, done=0 and both counters unchanged; abort in IDLE SHALL have no effect.
REQ-031 When CAR_SENSOR_SEQ_ABORT_EN is undefined, the abort and aborted ports SHALL be absent and sequences always run to completion.

Verification
REQ-032 Scenario: PHASE_CYCLES=2, reset, then start_enter for 1 cycle -> A/B = 10,10,11,11,01,01 and then 00 with done=1 for 1 cycle; enter_cnt=1, exit_cnt=0.
REQ-033 Scenario: start_exit for 1 cycle -> A/B = 01,01,11,11,10,10 and then 00 with done=1; exit_cnt=1.
REQ-034 Scenario: start_enter=start_exit=1 together -> enter pattern only; then start_exit pulsed during PH2 -> ignored; then start_exit held through the done cycle -> exit sequence begins after exactly one 00 cycle.
REQ-035 Scenario: reset_n=0 for one edge during PH2 -> next cycle A=B=0, busy=0, done=0, and both counters 0.
REQ-036 Scenario: CNT_W=2, four complete enter sequences -> enter_cnt steps 1,2,3,0.
REQ-037 Scenario: with CAR_SENSOR_SEQ_ABORT_EN defined, abort in PH2 -> next cycle A=B=0, aborted=1, done=0, and enter_cnt unchanged.
